// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and load/store (MEM).
// Data wins by default; IF is forced after STARVE_MAX back-to-back data grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ack,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    input  logic [2:0]        i_d_dmtype,
    output logic              o_d_ack,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [2:0]        o_mem_dmtype,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_stall_if,
    output logic              o_stall_mem,
    output logic              o_timeout_err
);

    localparam int unsigned       SC_W       = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0]   STARVE_LIM = SC_W'(STARVE_MAX);
    // Last BUSY cycle index: a transaction may occupy at most TIMEOUT BUSY cycles.
    localparam logic [7:0]        WD_LAST    = 8'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

    state_e            r_state, w_state_d;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_dmtype;
    logic [SC_W-1:0]   r_starve_cnt;
    logic [7:0]        r_wd_cnt;
    logic              r_timeout_err;
    logic              r_if_ack, r_d_ack;
    logic [DATA_W-1:0] r_if_rdata, r_d_rdata;

    logic              w_busy, w_grant_d, w_grant_i, w_finish, w_expire;
    logic [DATA_W-1:0] w_resp_data;

    assign w_busy      = (r_state == StBusyI) || (r_state == StBusyD);
    // A mem_ack in the final BUSY cycle still wins over the watchdog.
    assign w_expire    = w_busy && !i_mem_ack && (r_wd_cnt == WD_LAST);
    assign w_resp_data = i_mem_ack ? i_mem_rdata : ABORT_DATA;

    always_comb begin
        w_state_d = r_state;
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        w_finish  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_d_req && !(i_if_req && (r_starve_cnt >= STARVE_LIM))) begin
                    w_grant_d = 1'b1;
                    w_state_d = StBusyD;
                end else if (i_if_req) begin
                    w_grant_i = 1'b1;
                    w_state_d = StBusyI;
                end
            end
            StBusyI, StBusyD: begin
                if (i_mem_ack || w_expire) begin
                    w_finish  = 1'b1;
                    w_state_d = StResp;
                end
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_dmtype      <= '0;
            r_starve_cnt  <= '0;
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
            r_if_ack      <= 1'b0;
            r_d_ack       <= 1'b0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;

            if (w_grant_d) begin
                r_addr   <= i_d_addr;
                r_we     <= i_d_we;
                r_wdata  <= i_d_wdata;
                r_dmtype <= i_d_dmtype;
            end else if (w_grant_i) begin
                r_addr   <= i_if_addr;
                r_we     <= 1'b0;
                r_wdata  <= '0;
                r_dmtype <= '0;
            end

            if (w_grant_d || w_grant_i) begin
                r_wd_cnt <= '0;
            end else if (w_busy) begin
                r_wd_cnt <= r_wd_cnt + 8'd1;
            end

            if (w_grant_i) begin
                r_starve_cnt <= '0;
            end else if (w_grant_d && i_if_req && (r_starve_cnt < STARVE_LIM)) begin
                r_starve_cnt <= r_starve_cnt + SC_W'(1);
            end

            if (w_finish) begin
                if (r_state == StBusyI) begin
                    r_if_ack   <= 1'b1;
                    r_if_rdata <= w_resp_data;
                end else begin
                    r_d_ack    <= 1'b1;
                    r_d_rdata  <= w_resp_data;
                end
            end

            if (w_expire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign o_mem_req     = w_busy;
    assign o_mem_we      = (r_state == StBusyD) && r_we;
    assign o_mem_addr    = r_addr;
    assign o_mem_wdata   = r_wdata;
    assign o_mem_dmtype  = r_dmtype;
    assign o_if_ack      = r_if_ack;
    assign o_if_rdata    = r_if_rdata;
    assign o_d_ack       = r_d_ack;
    assign o_d_rdata     = r_d_rdata;
    assign o_stall_if    = i_if_req & ~r_if_ack;
    assign o_stall_mem   = i_d_req & ~r_d_ack;
    assign o_timeout_err = r_timeout_err;

endmodule
